// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep/capture block.
// Holds the fixed input count, the derived table width, the table and minterm types
// and the sweep FSM state encoding.
package tt_pkg;

  localparam int N_IN = 7;
  localparam int TT_W = 2 ** N_IN;

  typedef logic [TT_W-1:0] tt_t;
  typedef logic [N_IN-1:0] minterm_t;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    HOLD
  } sweep_state_t;

  localparam minterm_t LAST_MINTERM = minterm_t'(TT_W - 1);

endpackage

// File: rtl/tt_lat_align.sv
// Delay line that lines each swept minterm index up with its delayed function output.
// Latency: LAT cycles from vld_i/idx_i to vld_o/idx_o; LAT=0 is a straight wire.
// Backpressure: none, it shifts every cycle.
// Ports: clk, rst (async, active high), vld_i/idx_i in, vld_o/idx_o out.
module tt_lat_align
  import tt_pkg::*;
#(
  parameter int LAT = 0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     vld_i,
  input  minterm_t idx_i,
  output logic     vld_o,
  output minterm_t idx_o
);

  generate
    if (LAT == 0) begin : g_pass
      assign vld_o = vld_i;
      assign idx_o = idx_i;
      // No registers here, so clock and reset have nothing to drive.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
    end else begin : g_pipe
      logic [LAT-1:0] vld_q;
      minterm_t       idx_q [LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
        end else begin
          vld_q[0] <= vld_i;
          idx_q[0] <= idx_i;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
          end
        end
      end

      assign vld_o = vld_q[LAT-1];
      assign idx_o = idx_q[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps x through all 128 minterms, captures f_in per minterm into a truth table and counts ones.
// Latency: tt_valid rises after edge 128+LAT counted from the start edge.
// Backpressure: the result is held in HOLD until tt_ready; start is ignored outside IDLE.
// Ports: clk, rst (async, active high), start, busy, x, f_in, tt, ones, tt_valid, tt_ready.
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int LAT = 0  // function pipeline depth, legal 0..7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic [6:0] x,
  input  logic       f_in,
  output logic [127:0] tt,
  output logic [7:0] ones,
  output logic       tt_valid,
  input  logic       tt_ready
);

  sweep_state_t state_q, state_d;
  minterm_t     x_q, x_d;
  tt_t          tt_q, tt_d;
  logic [7:0]   ones_q, ones_d;

  logic         cap_vld;
  minterm_t     cap_idx;
  logic         cap_last;

  tt_lat_align #(.LAT(LAT)) u_align (
    .clk   (clk),
    .rst   (rst),
    .vld_i (state_q == SWEEP),
    .idx_i (x_q),
    .vld_o (cap_vld),
    .idx_o (cap_idx)
  );

  assign cap_last = cap_vld && (cap_idx == LAST_MINTERM);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    tt_d    = tt_q;
    ones_d  = ones_q;

    // Only aligned-valid samples touch the table, so f_in may be X otherwise.
    if (cap_vld) begin
      tt_d[cap_idx] = f_in;
      ones_d        = ones_q + 8'(f_in);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          x_d     = '0;
          tt_d    = '0;
          ones_d  = '0;
        end
      end
      SWEEP: begin
        // 127 + 1 wraps to 0, which is the value x holds through DRAIN.
        x_d = x_q + minterm_t'(1);
        // With LAT=0 the last capture coincides with x=127, so HOLD wins.
        if (cap_last)                  state_d = HOLD;
        else if (x_q == LAST_MINTERM)  state_d = DRAIN;
      end
      DRAIN: begin
        x_d = '0;
        if (cap_last) state_d = HOLD;
      end
      HOLD: begin
        if (tt_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
    end
  end

  assign x        = x_q;
  assign tt       = tt_q;
  assign ones     = ones_q;
  assign busy     = (state_q == SWEEP) || (state_q == DRAIN);
  assign tt_valid = (state_q == HOLD);

endmodule

// File: tb/tb_tt_sweep_capture.sv
module tb_tt_sweep_capture;

  logic         clk = 1'b0;
  logic         rst;

  // LAT=0 instance, function computed combinationally from x0
  logic         start0, busy0, f_in0, valid0, ready0;
  logic [6:0]   x0;
  logic [127:0] tt0;
  logic [7:0]   ones0;
  int           mode0;

  // LAT=3 instance, majority(x0,x3,x4) through a 3-stage register
  logic         start3, busy3, f_in3, valid3, ready3;
  logic [6:0]   x3;
  logic [127:0] tt3;
  logic [7:0]   ones3;
  logic [2:0]   fpipe;

  int checks = 0;
  int errors = 0;

  logic [127:0] q_tt[$];
  logic [7:0]   q_ones[$];
  logic [6:0]   q_x[$];

  always #5 clk = ~clk;

  tt_sweep_capture #(.LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .x(x0), .f_in(f_in0),
    .tt(tt0), .ones(ones0), .tt_valid(valid0), .tt_ready(ready0)
  );

  tt_sweep_capture #(.LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .x(x3), .f_in(f_in3),
    .tt(tt3), .ones(ones3), .tt_valid(valid3), .tt_ready(ready3)
  );

  function automatic logic fmodel(input int mode, input logic [6:0] k);
    case (mode)
      1:       return k[0];
      2:       return k[6];
      3:       return (k[0] & k[3]) | (k[0] & k[4]) | (k[3] & k[4]);
      default: return 1'b0;
    endcase
  endfunction

  assign f_in0 = fmodel(mode0, x0);

  always @(posedge clk) begin
    fpipe[0] <= fmodel(3, x3);
    fpipe[1] <= fpipe[0];
    fpipe[2] <= fpipe[1];
  end
  assign f_in3 = fpipe[2];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input int mode);
    logic [127:0] t;
    logic [7:0]   c;
    logic [6:0]   k;
    t = '0;
    c = '0;
    for (int i = 0; i < 128; i++) begin
      k = 7'(i);
      t[i] = fmodel(mode, k);
      c = c + 8'(t[i]);
    end
    q_tt.push_back(t);
    q_ones.push_back(c);
  endtask

  task automatic pop_compare(input string tag, input logic [127:0] tt_obs, input logic [7:0] ones_obs,
                             output logic [127:0] exp_tt);
    logic [7:0] exp_ones;
    exp_tt = '0;
    if (q_tt.size() == 0) begin
      check({tag, "_queue_empty"}, 128'(q_tt.size()), 128'd1);
      return;
    end
    exp_tt   = q_tt.pop_front();
    exp_ones = q_ones.pop_front();
    check({tag, "_tt"}, tt_obs, exp_tt);
    check({tag, "_ones"}, 128'(ones_obs), 128'(exp_ones));
  endtask

  // Waits for valid0, counting edges since the start edge.
  task automatic wait_valid0(output int n);
    n = 0;
    while (!valid0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic sweep0(input int mode, input string tag);
    int n;
    logic [127:0] e;
    mode0 = mode;
    push_expected(mode);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    check({tag, "_busy"}, 128'(busy0), 128'd1);
    wait_valid0(n);
    check({tag, "_latency"}, 128'(n), 128'd128);
    pop_compare(tag, tt0, ones0, e);
    @(posedge clk); #1;
    check({tag, "_idle_valid"}, 128'(valid0), 128'd0);
    check({tag, "_idle_busy"}, 128'(busy0), 128'd0);
  endtask

  task automatic sweep3(input bit pulses, input string tag);
    int n;
    logic [127:0] e;
    logic [6:0] k;
    push_expected(3);
    for (int i = 0; i < 128; i++) q_x.push_back(7'(i));
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    n = 0;
    while (!valid3 && n < 400) begin
      if (n < 128) begin
        if (q_x.size() > 0) check({tag, "_x_seq"}, 128'(x3), 128'(q_x.pop_front()));
      end else begin
        check({tag, "_drain_x"}, 128'(x3), 128'd0);
        check({tag, "_drain_busy"}, 128'(busy3), 128'd1);
      end
      start3 = pulses && (n == 40 || n == 129);
      @(posedge clk); #1;
      n++;
    end
    start3 = 1'b0;
    check({tag, "_latency"}, 128'(n), 128'd131);
    pop_compare(tag, tt3, ones3, e);
    check({tag, "_ones64"}, 128'(ones3), 128'd64);
    for (int i = 0; i < 128; i++) begin
      k = 7'(i);
      check({tag, "_bit"}, 128'(tt3[i]), 128'(fmodel(3, k)));
    end
    @(posedge clk); #1;
    check({tag, "_idle_valid"}, 128'(valid3), 128'd0);
    check({tag, "_idle_busy"}, 128'(busy3), 128'd0);
  endtask

  initial begin
    int n;
    logic [127:0] e;
    rst = 1'b1;
    start0 = 1'b0; start3 = 1'b0;
    ready0 = 1'b1; ready3 = 1'b1;
    mode0 = 0;
    fpipe = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_x", 128'(x0), 128'd0);
    check("reset_tt", tt0, 128'd0);
    check("reset_ones", 128'(ones0), 128'd0);
    check("reset_valid", 128'(valid0), 128'd0);
    check("reset_busy", 128'(busy0), 128'd0);
    check("reset_valid3", 128'(valid3), 128'd0);

    // Constant zero, x0 and x6 tables on the LAT=0 instance
    sweep0(0, "zero");
    sweep0(1, "x0");
    sweep0(2, "x6");

    // Majority through a 3-stage function pipeline
    sweep3(1'b0, "maj_lat3");

    // Start held high, consumer stalls 20 cycles in HOLD
    mode0 = 1;
    push_expected(1);
    ready0 = 1'b0;
    start0 = 1'b1;
    @(posedge clk); #1;
    wait_valid0(n);
    check("stall_latency", 128'(n), 128'd128);
    pop_compare("stall", tt0, ones0, e);
    repeat (20) begin
      @(posedge clk); #1;
      check("stall_tt", tt0, e);
      check("stall_ones", 128'(ones0), 128'd64);
      check("stall_valid", 128'(valid0), 128'd1);
      check("stall_busy", 128'(busy0), 128'd0);
    end
    ready0 = 1'b1;
    @(posedge clk); #1;
    check("release_idle_valid", 128'(valid0), 128'd0);
    check("release_idle_busy", 128'(busy0), 128'd0);
    @(posedge clk); #1;
    check("restart_busy", 128'(busy0), 128'd1);
    check("restart_x", 128'(x0), 128'd0);
    start0 = 1'b0;
    push_expected(1);
    wait_valid0(n);
    check("restart_latency", 128'(n), 128'd128);
    pop_compare("restart", tt0, ones0, e);
    @(posedge clk); #1;

    // Reset in the middle of a sweep
    mode0 = 3;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0;
    while (x0 != 7'd60 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reached60", 128'(x0), 128'd60);
    rst = 1'b1;
    #1;
    check("abort_x", 128'(x0), 128'd0);
    check("abort_tt", tt0, 128'd0);
    check("abort_busy", 128'(busy0), 128'd0);
    check("abort_valid", 128'(valid0), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sweep0(3, "after_abort");

    // Start pulses in SWEEP and DRAIN are ignored
    sweep3(1'b1, "pulse_lat3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
